gp9001_cpu_if: RTL and testbench

- CPU-side command engine of the GP9001 video controller.
- Consumes the level op strobes (SELECT_REG, WRITE_REG, WRITE_RAM, READ_RAM_H/L, SET_RAM_PTR) issued by the 68k bus block; holds each op until executed, then returns ACK and read data.
- Owns the register-select latch, the video register file and the auto-incrementing VRAM pointer.
- Arbitrates for the shared VRAM port with a request/grant handshake against the renderer.

---
 rtl/gp9001_cpu_if_if.sv | 21 ++
 rtl/gp9001_cpu_if.sv | 171 +++++++++++++++++
 tb/tb_gp9001_cpu_if.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gp9001_cpu_if_if.sv
// rtl/gp9001_cpu_if_if.sv - VRAM request/grant port shared between CPU engine and renderer
interface gp9001_cpu_if_if #(
    parameter int AW = 14
) ();
    logic          VRAM_REQ;
    logic          VRAM_WE;
    logic [AW-1:0] VRAM_ADDR;
    logic [15:0]   VRAM_DIN;
    logic [15:0]   VRAM_DOUT;
    logic          VRAM_GNT;

    modport master (
        output VRAM_REQ, VRAM_WE, VRAM_ADDR, VRAM_DIN,
        input  VRAM_DOUT, VRAM_GNT
    );

    modport slave (
        input  VRAM_REQ, VRAM_WE, VRAM_ADDR, VRAM_DIN,
        output VRAM_DOUT, VRAM_GNT
    );
endinterface

// File: rtl/gp9001_cpu_if.sv
// rtl/gp9001_cpu_if.sv - GP9001 CPU command engine: register file, VRAM pointer, VRAM arbitration
// Optional: GP9001_VBL_LOCK_EN holds VRAM ops until vertical blank (LVBL low).
module gp9001_cpu_if #(
    parameter int AW      = 14,
    parameter int REG_NUM = 16
) (
    input  logic                    CLK96,
    input  logic                    RESET96,
    input  logic                    OP_SELECT_REG,
    input  logic                    OP_WRITE_REG,
    input  logic                    OP_WRITE_RAM,
    input  logic                    OP_READ_RAM_H,
    input  logic                    OP_READ_RAM_L,
    input  logic                    OP_SET_RAM_PTR,
    input  logic [15:0]             DIN,
    input  logic                    LVBL,
    output logic                    ACK,
    output logic [15:0]             DOUT,
    output logic [16*REG_NUM-1:0]   REGS,
    gp9001_cpu_if_if.master         vram
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VREQ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    sel_q, sel_d;
    logic [15:0]   dout_q, dout_d;
    logic          ack_q, ack_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   vdin_q, vdin_d;
    logic          incr_q, incr_d;
    logic          pend_q, pend_d;
    logic          reg_we;
    logic          any_op;
    logic          vram_go;
    logic [15:0]   regs_q [REG_NUM];

`ifdef GP9001_VBL_LOCK_EN
    assign vram_go = ~LVBL;
`else
    logic unused_lvbl;
    assign unused_lvbl = LVBL;
    assign vram_go     = 1'b1;
`endif

    assign any_op = OP_SELECT_REG | OP_WRITE_REG | OP_WRITE_RAM |
                    OP_READ_RAM_H | OP_READ_RAM_L | OP_SET_RAM_PTR;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        ack_d   = ack_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        vdin_d  = vdin_q;
        incr_d  = incr_q;
        pend_d  = pend_q;
        reg_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    // VRAM op already latched, only waiting for the blank window
                    if (vram_go) begin
                        req_d   = 1'b1;
                        addr_d  = ptr_q;
                        pend_d  = 1'b0;
                        state_d = ST_VREQ;
                    end
                end else if (any_op) begin
                    if (OP_SET_RAM_PTR) begin
                        ptr_d   = DIN[AW-1:0];
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (OP_SELECT_REG) begin
                        sel_d   = DIN[7:0];
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (OP_WRITE_REG) begin
                        reg_we  = ({1'b0, sel_q} < 9'(REG_NUM));
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        we_d   = OP_WRITE_RAM;
                        incr_d = OP_WRITE_RAM | OP_READ_RAM_L;
                        vdin_d = DIN;
                        if (vram_go) begin
                            req_d   = 1'b1;
                            addr_d  = ptr_q;
                            state_d = ST_VREQ;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_VREQ: begin
                if (vram.VRAM_GNT) begin
                    if (!we_q) dout_d = vram.VRAM_DOUT;
                    if (incr_q) ptr_d = ptr_q + 1'b1;
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!any_op) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            vdin_q  <= '0;
            incr_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            vdin_q  <= vdin_d;
            incr_q  <= incr_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[sel_q[RW-1:0]] <= DIN;
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_regs
        assign REGS[16*g +: 16] = regs_q[g];
    end

    assign ACK            = ack_q;
    assign DOUT           = dout_q;
    assign vram.VRAM_REQ  = req_q;
    assign vram.VRAM_WE   = we_q;
    assign vram.VRAM_ADDR = addr_q;
    assign vram.VRAM_DIN  = vdin_q;

endmodule

// File: tb/tb_gp9001_cpu_if.sv
// tb/tb_gp9001_cpu_if.sv - randomized self-checking bench for gp9001_cpu_if with VRAM renderer model
module tb_gp9001_cpu_if;

    logic          CLK96 = 1'b0;
    logic          RESET96;
    logic          OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM;
    logic          OP_READ_RAM_H, OP_READ_RAM_L, OP_SET_RAM_PTR;
    logic [15:0]   DIN;
    logic          LVBL;
    logic          ACK;
    logic [15:0]   DOUT;
    logic [255:0]  REGS;

    gp9001_cpu_if_if #(.AW(14)) vbus ();

    gp9001_cpu_if #(.AW(14), .REG_NUM(16)) dut (
        .CLK96         (CLK96),
        .RESET96       (RESET96),
        .OP_SELECT_REG (OP_SELECT_REG),
        .OP_WRITE_REG  (OP_WRITE_REG),
        .OP_WRITE_RAM  (OP_WRITE_RAM),
        .OP_READ_RAM_H (OP_READ_RAM_H),
        .OP_READ_RAM_L (OP_READ_RAM_L),
        .OP_SET_RAM_PTR(OP_SET_RAM_PTR),
        .DIN           (DIN),
        .LVBL          (LVBL),
        .ACK           (ACK),
        .DOUT          (DOUT),
        .REGS          (REGS),
        .vram          (vbus.master)
    );

    always #5 CLK96 = ~CLK96;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem [16384];
    logic [13:0] m_ptr;
    logic [7:0]  m_sel;
    logic [15:0] m_regs [16];
    logic [15:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // kinds: 0 SET_RAM_PTR, 1 SELECT_REG, 2 WRITE_REG, 3 WRITE_RAM, 4 READ_RAM_L, 5 READ_RAM_H
    task automatic set_op(input int kind, input logic v);
        OP_SET_RAM_PTR = (kind == 0) & v;
        OP_SELECT_REG  = (kind == 1) & v;
        OP_WRITE_REG   = (kind == 2) & v;
        OP_WRITE_RAM   = (kind == 3) & v;
        OP_READ_RAM_L  = (kind == 4) & v;
        OP_READ_RAM_H  = (kind == 5) & v;
    endtask

    task automatic model_reset();
        m_ptr  = '0;
        m_sel  = '0;
        m_dout = '0;
        for (int k = 0; k < 16; k++) m_regs[k] = '0;
    endtask

    task automatic check_state();
        for (int k = 0; k < 16; k++) chk("regs", 32'(REGS[16*k +: 16]), 32'(m_regs[k]));
        chk("dout", 32'(DOUT), 32'(m_dout));
    endtask

    task automatic run_op(input int kind, input logic [15:0] din, input int gdly, input int hold);
        int          lat;
        int          nreq;
        logic [13:0] eaddr;
        logic [15:0] edata;
        @(negedge CLK96);
        eaddr = m_ptr;
        edata = mem[m_ptr];
        set_op(kind, 1'b1);
        DIN = din;
        lat = 0;
        nreq = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK96);
`ifndef GP9001_VBL_LOCK_EN
            LVBL = 1'($urandom);
`endif
            if (ACK) begin
                lat = c;
                break;
            end
            if (vbus.VRAM_REQ) begin
                nreq++;
                chk("vram_addr", 32'(vbus.VRAM_ADDR), 32'(eaddr));
                chk("vram_we", 32'(vbus.VRAM_WE), 32'(kind == 3));
                if (kind == 3) chk("vram_din", 32'(vbus.VRAM_DIN), 32'(din));
                if (nreq == gdly + 1) begin
                    vbus.VRAM_GNT = 1'b1;
                    if (vbus.VRAM_WE) mem[vbus.VRAM_ADDR] = vbus.VRAM_DIN;
                    else vbus.VRAM_DOUT = mem[vbus.VRAM_ADDR];
                end else begin
                    vbus.VRAM_GNT  = 1'b0;
                    vbus.VRAM_DOUT = 16'($urandom);
                end
            end else begin
                vbus.VRAM_GNT = 1'b0;
            end
        end
        vbus.VRAM_GNT = 1'b0;
        chk("ack_latency", 32'(lat), (kind >= 3) ? 32'(2 + gdly) : 32'd1);
        chk("req_cycles", 32'(nreq), (kind >= 3) ? 32'(gdly + 1) : 32'd0);
        case (kind)
            0: m_ptr = din[13:0];
            1: m_sel = din[7:0];
            2: if (m_sel < 16) m_regs[m_sel[3:0]] = din;
            3: m_ptr = m_ptr + 14'd1;
            4: begin m_dout = edata; m_ptr = m_ptr + 14'd1; end
            default: m_dout = edata;
        endcase
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK96);
            chk("ack_hold", 32'(ACK), 32'd1);
            chk("req_hold", 32'(vbus.VRAM_REQ), 32'd0);
            vbus.VRAM_GNT = 1'($urandom);
        end
        set_op(0, 1'b0);
        vbus.VRAM_GNT = 1'b0;
        DIN = 16'($urandom);
        @(negedge CLK96);
        chk("ack_release", 32'(ACK), 32'd0);
        check_state();
    endtask

    initial begin
        RESET96 = 1'b1;
        set_op(0, 1'b0);
        DIN = '0;
        LVBL = 1'b0;
        vbus.VRAM_GNT = 1'b0;
        vbus.VRAM_DOUT = '0;
        for (int a = 0; a < 16384; a++) mem[a] = 16'($urandom);
        model_reset();
        #12;
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_req", 32'(vbus.VRAM_REQ), 32'd0);
        chk("rst_addr", 32'(vbus.VRAM_ADDR), 32'd0);
        chk("rst_regs_zero", 32'(REGS == '0), 32'd1);
        chk("rst_dout", 32'(DOUT), 32'd0);
        @(negedge CLK96);
        RESET96 = 1'b0;

        run_op(1, 16'h0005, 0, 0);
        run_op(2, 16'hBEEF, 0, 0);
        run_op(0, 16'h0100, 0, 0);
        run_op(3, 16'h1111, 0, 0);
        run_op(3, 16'h2222, 0, 0);
        run_op(3, 16'h3333, 0, 0);
        run_op(0, 16'h3FFF, 0, 1);
        run_op(3, 16'h5A5A, 0, 0);
        mem[0] = 16'hA5A5;
        run_op(5, 16'h0000, 5, 0);
        run_op(4, 16'h0000, 1, 10);
        run_op(1, 16'h0013, 0, 0);
        run_op(2, 16'hDEAD, 0, 2);

        for (int i = 0; i < 200; i++) begin
            int          kind;
            logic [15:0] d;
            kind = int'($urandom_range(0, 5));
            d = 16'($urandom);
            if (kind == 1) d = 16'($urandom_range(0, 20));
            run_op(kind, d, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // reset while a request is outstanding
        @(negedge CLK96);
        set_op(3, 1'b1);
        DIN = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK96);
            if (vbus.VRAM_REQ) break;
        end
        chk("rst_mid_req_seen", 32'(vbus.VRAM_REQ), 32'd1);
        #2 RESET96 = 1'b1;
        #1;
        chk("rst_mid_req", 32'(vbus.VRAM_REQ), 32'd0);
        chk("rst_mid_ack", 32'(ACK), 32'd0);
        chk("rst_mid_regs", 32'(REGS == '0), 32'd1);
        chk("rst_mid_dout", 32'(DOUT), 32'd0);
        model_reset();
        @(negedge CLK96);
        set_op(0, 1'b0);
        RESET96 = 1'b0;
        run_op(3, 16'h4321, 2, 0);
        run_op(5, 16'h0000, 0, 0);

`ifdef GP9001_VBL_LOCK_EN
        begin
            logic [13:0] eaddr;
            LVBL = 1'b1;
            @(negedge CLK96);
            eaddr = m_ptr;
            set_op(3, 1'b1);
            DIN = 16'hC0DE;
            repeat (4) begin
                @(negedge CLK96);
                chk("lock_req", 32'(vbus.VRAM_REQ), 32'd0);
                chk("lock_ack", 32'(ACK), 32'd0);
            end
            LVBL = 1'b0;
            @(negedge CLK96);
            chk("lock_req_go", 32'(vbus.VRAM_REQ), 32'd1);
            chk("lock_addr", 32'(vbus.VRAM_ADDR), 32'(eaddr));
            chk("lock_din", 32'(vbus.VRAM_DIN), 32'h0000C0DE);
            vbus.VRAM_GNT = 1'b1;
            mem[vbus.VRAM_ADDR] = vbus.VRAM_DIN;
            @(negedge CLK96);
            vbus.VRAM_GNT = 1'b0;
            chk("lock_done_ack", 32'(ACK), 32'd1);
            set_op(0, 1'b0);
            @(negedge CLK96);
            chk("lock_release", 32'(ACK), 32'd0);
            m_ptr = m_ptr + 14'd1;
            run_op(4, 16'h0000, 0, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
